// File: rtl/mem_rmw_master_pkg.sv
// Shared encodings for the memory RMW initiator: bus widths, access sizes, FSM states.
package mem_rmw_master_pkg;

   localparam int          MemAddrBus = 32;
   localparam int          MemBus     = 32;
   localparam logic [31:0] ZeroWord   = 32'h0000_0000;
   localparam logic        RstEnable  = 1'b0;

   localparam logic [1:0] MemSizeByte = 2'b00;
   localparam logic [1:0] MemSizeHalf = 2'b01;
   localparam logic [1:0] MemSizeWord = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RD   = 2'd1,
      ST_WR   = 2'd2,
      ST_RESP = 2'd3
   } mem_state_e;

   // Encoding 2'b11 behaves as a word access everywhere.
   function automatic logic size_is_word(input logic [1:0] size);
      return size[1];
   endfunction

   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
      case (size)
         MemSizeByte: return 1'b0;
         MemSizeHalf: return lane[0];
         default:     return lane != 2'b00;
      endcase
   endfunction

endpackage

// File: rtl/mem_lane_mux.sv
// Combinational lane logic: extracts and extends a load lane from a RAM word and
// merges store data into the selected lane of the old word.
module mem_lane_mux
   import mem_rmw_master_pkg::*;
(
   input  logic [MemBus-1:0] rword,
   input  logic [MemBus-1:0] wdata,
   input  logic [1:0]        size,
   input  logic [1:0]        lane,
   input  logic              uns,
   output logic [MemBus-1:0] load_data,
   output logic [MemBus-1:0] merged
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      case (lane)
         2'd0:    byte_sel = rword[7:0];
         2'd1:    byte_sel = rword[15:8];
         2'd2:    byte_sel = rword[23:16];
         default: byte_sel = rword[31:24];
      endcase
      half_sel  = lane[1] ? rword[31:16] : rword[15:0];
      load_data = rword;
      merged    = wdata;
      if (size == MemSizeByte) begin
         load_data = {{24{byte_sel[7] & ~uns}}, byte_sel};
         merged    = rword;
         case (lane)
            2'd0:    merged[7:0]   = wdata[7:0];
            2'd1:    merged[15:8]  = wdata[7:0];
            2'd2:    merged[23:16] = wdata[7:0];
            default: merged[31:24] = wdata[7:0];
         endcase
      end else if (size == MemSizeHalf) begin
         // lane[0] is ignored so misaligned halves fall back to lane addr[1].
         load_data = {{16{half_sel[15] & ~uns}}, half_sel};
         merged    = rword;
         if (lane[1]) merged[31:16] = wdata[15:0];
         else         merged[15:0]  = wdata[15:0];
      end
   end

endmodule

// File: rtl/mem_rmw_master.sv
// Load/store initiator for the word-wide data RAM; sub-word stores become read-modify-write.
// Define MEM_MISALIGN_TRAP_EN to report misaligned requests on rsp_err_o instead of executing them.
module mem_rmw_master
   import mem_rmw_master_pkg::*;
#(
   parameter int ADDR_W = MemAddrBus,
   parameter int DATA_W = MemBus
) (
   input  logic              clk,
   input  logic              rst,
   // Request: accepted on a rising edge where req_valid_i && req_ready_o; no response backpressure.
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic              req_we_i,
   input  logic [1:0]        req_size_i,
   input  logic              req_unsigned_i,
   input  logic [ADDR_W-1:0] req_addr_i,
   input  logic [DATA_W-1:0] req_wdata_i,
   output logic              rsp_valid_o,
   output logic [DATA_W-1:0] rsp_rdata_o,
   output logic              rsp_err_o,
   output logic              ram_we_o,
   output logic [ADDR_W-1:0] ram_addr_o,
   output logic [DATA_W-1:0] ram_wdata_o,
   input  logic [DATA_W-1:0] ram_rdata_i,
   output logic [1:0]        state_dbg
);

   mem_state_e        state_q, state_d;
   logic [ADDR_W-1:0] addr_q;
   logic [1:0]        size_q;
   logic              we_q, uns_q;
   logic [DATA_W-1:0] wword_q, rdata_q;
   logic [DATA_W-1:0] load_data, merged;
   logic              accept, trap;

   assign accept = req_valid_i && (state_q == ST_IDLE);

`ifdef MEM_MISALIGN_TRAP_EN
   logic err_q;
   assign trap = is_misaligned(req_size_i, req_addr_i[1:0]);

   always_ff @(posedge clk or negedge rst) begin
      if (rst == RstEnable) err_q <= 1'b0;
      else if (accept)      err_q <= trap;
   end
   assign rsp_err_o = err_q;
`else
   assign trap      = 1'b0;
   assign rsp_err_o = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (rst == RstEnable) state_q <= ST_IDLE;
      else                  state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid_i) begin
               if (trap)                                       state_d = ST_RESP;
               else if (req_we_i && size_is_word(req_size_i))  state_d = ST_WR;
               else                                            state_d = ST_RD;
            end
         end
         ST_RD:   state_d = we_q ? ST_WR : ST_RESP;
         ST_WR:   state_d = ST_RESP;
         default: state_d = ST_IDLE;
      endcase
   end

   mem_lane_mux u_lane_mux (
      .rword     (ram_rdata_i),
      .wdata     (wword_q),
      .size      (size_q),
      .lane      (addr_q[1:0]),
      .uns       (uns_q),
      .load_data (load_data),
      .merged    (merged)
   );

   // wword_q starts as the store data and is replaced by the merged word in RD.
   always_ff @(posedge clk or negedge rst) begin
      if (rst == RstEnable) begin
         addr_q  <= '0;
         size_q  <= MemSizeByte;
         we_q    <= 1'b0;
         uns_q   <= 1'b0;
         wword_q <= ZeroWord;
         rdata_q <= ZeroWord;
      end else if (accept) begin
         addr_q  <= req_addr_i;
         size_q  <= req_size_i;
         we_q    <= req_we_i;
         uns_q   <= req_unsigned_i;
         wword_q <= req_wdata_i;
         rdata_q <= ZeroWord;
      end else if (state_q == ST_RD) begin
         if (we_q) wword_q <= merged;
         else      rdata_q <= load_data;
      end
   end

   always_comb begin
      req_ready_o = (state_q == ST_IDLE);
      rsp_valid_o = (state_q == ST_RESP);
      rsp_rdata_o = rdata_q;
      ram_we_o    = (state_q == ST_WR);
      ram_addr_o  = '0;
      ram_wdata_o = '0;
      if (state_q == ST_RD || state_q == ST_WR) ram_addr_o = {addr_q[ADDR_W-1:2], 2'b00};
      if (state_q == ST_WR)                     ram_wdata_o = wword_q;
      state_dbg   = state_q;
   end

endmodule

// File: tb/tb_mem_rmw_master.sv
// Bench for mem_rmw_master: behavioural RAM, request driver, expected-response scoreboard.
module tb_mem_rmw_master;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready, req_we, req_uns;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic        rsp_valid, rsp_err;
   logic [31:0] rsp_rdata;
   logic        ram_we;
   logic [31:0] ram_addr, ram_wdata, ram_rdata;
   logic [1:0]  state_dbg;

   logic [31:0] mem     [0:1023];
   logic [31:0] ref_mem [0:1023];
   logic        pre_we = 1'b0;
   logic [9:0]  pre_idx;
   logic [31:0] pre_data;

   int checks = 0;
   int errors = 0;
   int cyc = 0, rsp_count = 0, acc_count = 0, we_run = 0, touch = 0;

   logic [31:0] exp_q[$];
   logic        exp_err_q[$];
   int          exp_lat_q[$];
   int          acc_q[$];

   mem_rmw_master dut (
      .clk            (clk),
      .rst            (rst_n),
      .req_valid_i    (req_valid),
      .req_ready_o    (req_ready),
      .req_we_i       (req_we),
      .req_size_i     (req_size),
      .req_unsigned_i (req_uns),
      .req_addr_i     (req_addr),
      .req_wdata_i    (req_wdata),
      .rsp_valid_o    (rsp_valid),
      .rsp_rdata_o    (rsp_rdata),
      .rsp_err_o      (rsp_err),
      .ram_we_o       (ram_we),
      .ram_addr_o     (ram_addr),
      .ram_wdata_o    (ram_wdata),
      .ram_rdata_i    (ram_rdata),
      .state_dbg      (state_dbg)
   );

   // clock / reset / RAM
   always #5 clk = ~clk;

   assign ram_rdata = mem[ram_addr[11:2]];
   always @(posedge clk) begin
      if (ram_we)      mem[ram_addr[11:2]] <= ram_wdata;
      else if (pre_we) mem[pre_idx]        <= pre_data;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] a,
                                              input logic [1:0] size, input logic uns);
      logic [31:0] v;
      if (size == 2'b00) begin
         v = (w >> (8 * a)) & 32'h0000_00FF;
         if (!uns && v[7]) v = v | 32'hFFFF_FF00;
      end else if (size == 2'b01) begin
         v = (w >> (16 * a[1])) & 32'h0000_FFFF;
         if (!uns && v[15]) v = v | 32'hFFFF_0000;
      end else begin
         v = w;
      end
      return v;
   endfunction

   function automatic logic [31:0] model_merge(input logic [31:0] w, input logic [1:0] a,
                                               input logic [1:0] size, input logic [31:0] d);
      logic [31:0] m;
      if (size == 2'b00) begin
         m = 32'h0000_00FF << (8 * a);
         return (w & ~m) | ((d << (8 * a)) & m);
      end else if (size == 2'b01) begin
         m = 32'h0000_FFFF << (16 * a[1]);
         return (w & ~m) | ((d << (16 * a[1])) & m);
      end
      return d;
   endfunction

   // scoreboard monitor, sampled on the falling edge
   always @(negedge clk) begin : monitor
      logic [31:0] e;
      logic        ee;
      int          el, ac;
      cyc++;
      if (ram_we || ram_addr != 32'h0) touch++;
      if (ram_we) we_run++;
      else if (we_run != 0) begin
         chk("we_width", 32'(we_run), 32'd1);
         we_run = 0;
      end
      if (rst_n && req_valid && req_ready) begin
         acc_count++;
         acc_q.push_back(cyc);
      end
      if (rsp_valid) begin
         rsp_count++;
         if (exp_q.size() == 0 || acc_q.size() == 0) begin
            chk("unexpected_rsp", 32'd1, 32'd0);
         end else begin
            e  = exp_q.pop_front();
            ee = exp_err_q.pop_front();
            el = exp_lat_q.pop_front();
            ac = acc_q.pop_front();
            chk("rsp_rdata", rsp_rdata, e);
            chk("rsp_err", {31'd0, rsp_err}, {31'd0, ee});
            chk("latency", 32'(cyc - ac), 32'(el));
            chk("resp_ram_idle", {31'd0, ram_we} | ram_addr | ram_wdata, 32'd0);
         end
      end
   end

   // driver tasks
   task automatic preload(input logic [31:0] addr, input logic [31:0] data);
      pre_idx  = addr[11:2];
      pre_data = data;
      pre_we   = 1'b1;
      @(posedge clk);
      #1;
      pre_we = 1'b0;
      ref_mem[addr[11:2]] = data;
   endtask

   task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_data, input logic exp_err,
                         input int exp_lat, input logic hold);
      int n;
      req_we    = we;
      req_size  = size;
      req_uns   = uns;
      req_addr  = addr;
      req_wdata = wdata;
      req_valid = 1'b1;
      exp_q.push_back(exp_data);
      exp_err_q.push_back(exp_err);
      exp_lat_q.push_back(exp_lat);
      n = 0;
      @(negedge clk);
      while (!req_ready && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (n >= 40) chk("accept_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
      if (!hold) req_valid = 1'b0;
   endtask

   task automatic mop(input logic we, input logic [1:0] size, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wdata, input logic hold);
      logic [31:0] w;
      w = ref_mem[addr[11:2]];
      if (we) begin
         ref_mem[addr[11:2]] = model_merge(w, addr[1:0], size, wdata);
         do_req(1'b1, size, uns, addr, wdata, 32'h0, 1'b0, size[1] ? 2 : 3, hold);
      end else begin
         do_req(1'b0, size, uns, addr, wdata, model_load(w, addr[1:0], size, uns), 1'b0, 2, hold);
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 40) begin
         @(posedge clk);
         n++;
      end
      #1;
      if (exp_q.size() != 0) begin
         chk("drain_timeout", 32'(exp_q.size()), 32'd0);
         exp_q.delete();
         exp_err_q.delete();
         exp_lat_q.delete();
         acc_q.delete();
      end
   endtask

   initial begin : stimulus
      int          n, a0, r0, t0;
      logic [1:0]  sz;
      logic [31:0] ad;
      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_size  = 2'b00;
      req_uns   = 1'b0;
      req_addr  = 32'h0;
      req_wdata = 32'h0;
      repeat (2) @(negedge clk);
      chk("rst_ready", {31'd0, req_ready}, 32'd1);
      chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_rdata", rsp_rdata, 32'd0);
      chk("rst_err", {31'd0, rsp_err}, 32'd0);
      chk("rst_ram_we", {31'd0, ram_we}, 32'd0);
      chk("rst_ram_addr", ram_addr, 32'd0);
      chk("rst_ram_wdata", ram_wdata, 32'd0);
      chk("rst_state", {30'd0, state_dbg}, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // word store then word load
      do_req(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1'b0);
      drain();
      chk("mem_100", mem[32'h100 >> 2], 32'hDEADBEEF);
      do_req(1'b0, 2'b10, 1'b1, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 2, 1'b0);
      drain();

      // byte RMW preserves the other lanes
      preload(32'h200, 32'h11223344);
      do_req(1'b1, 2'b00, 1'b0, 32'h201, 32'h123456AA, 32'h0, 1'b0, 3, 1'b0);
      drain();
      chk("mem_200", mem[32'h200 >> 2], 32'h1122AA44);

      // load extension, then store immediately followed by a load
      preload(32'h300, 32'h8000FF7F);
      do_req(1'b0, 2'b00, 1'b0, 32'h300, 32'h0, 32'h0000007F, 1'b0, 2, 1'b0);
      do_req(1'b0, 2'b00, 1'b0, 32'h301, 32'h0, 32'hFFFFFFFF, 1'b0, 2, 1'b0);
      do_req(1'b0, 2'b01, 1'b1, 32'h302, 32'h0, 32'h00008000, 1'b0, 2, 1'b0);
      do_req(1'b0, 2'b01, 1'b0, 32'h302, 32'h0, 32'hFFFF8000, 1'b0, 2, 1'b0);
      do_req(1'b1, 2'b01, 1'b0, 32'h302, 32'h1234BEEF, 32'h0, 1'b0, 3, 1'b1);
      do_req(1'b0, 2'b10, 1'b0, 32'h300, 32'h0, 32'hBEEFFF7F, 1'b0, 2, 1'b0);
      do_req(1'b0, 2'b11, 1'b0, 32'h300, 32'h0, 32'hBEEFFF7F, 1'b0, 2, 1'b0);
      drain();

      // misaligned accesses
      preload(32'h400, 32'h1234ABCD);
      t0 = touch;
`ifdef MEM_MISALIGN_TRAP_EN
      do_req(1'b0, 2'b01, 1'b0, 32'h401, 32'h0, 32'h0, 1'b1, 1, 1'b0);
      do_req(1'b0, 2'b10, 1'b0, 32'h403, 32'h0, 32'h0, 1'b1, 1, 1'b0);
      drain();
      chk("trap_no_ram", 32'(touch - t0), 32'd0);
`else
      do_req(1'b0, 2'b01, 1'b0, 32'h401, 32'h0, 32'hFFFFABCD, 1'b0, 2, 1'b0);
      do_req(1'b0, 2'b10, 1'b0, 32'h403, 32'h0, 32'h1234ABCD, 1'b0, 2, 1'b0);
      drain();
      chk("misalign_ram_used", {31'd0, touch != t0}, 32'd1);
`endif

      // reset during the RD cycle of a byte RMW
      preload(32'h500, 32'h55555555);
      r0        = rsp_count;
      req_we    = 1'b1;
      req_size  = 2'b00;
      req_uns   = 1'b0;
      req_addr  = 32'h500;
      req_wdata = 32'h0000005A;
      req_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!req_ready && n < 40) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      chk("rmw_in_rd", {30'd0, state_dbg}, 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("rst_we_async", {31'd0, ram_we}, 32'd0);
      chk("rst_mid_ready", {31'd0, req_ready}, 32'd1);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      acc_q.delete();
      repeat (4) @(posedge clk);
      #1;
      chk("rst_mem_500", mem[32'h500 >> 2], 32'h55555555);
      chk("rst_no_rsp", 32'(rsp_count - r0), 32'd0);

      // four back-to-back word loads with req_valid held high
      a0 = acc_count;
      r0 = rsp_count;
      do_req(1'b0, 2'b10, 1'b1, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 2, 1'b1);
      do_req(1'b0, 2'b10, 1'b1, 32'h200, 32'h0, 32'h1122AA44, 1'b0, 2, 1'b1);
      do_req(1'b0, 2'b10, 1'b1, 32'h300, 32'h0, 32'hBEEFFF7F, 1'b0, 2, 1'b1);
      do_req(1'b0, 2'b10, 1'b1, 32'h500, 32'h0, 32'h55555555, 1'b0, 2, 1'b0);
      drain();
      chk("b2b_accepts", 32'(acc_count - a0), 32'd4);
      chk("b2b_rsps", 32'(rsp_count - r0), 32'd4);

      // random aligned mix against the reference memory
      for (int i = 0; i < 16; i++) preload(32'h600 + 32'(i * 4), $urandom);
      for (int i = 0; i < 24; i++) begin
         sz = 2'($urandom_range(0, 2));
         ad = 32'h600 + 32'($urandom_range(0, 15) * 4);
         if (sz == 2'b00)      ad = ad + 32'($urandom_range(0, 3));
         else if (sz == 2'b01) ad = ad + 32'($urandom_range(0, 1) * 2);
         mop(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), ad, $urandom, 1'b0);
      end
      drain();
      for (int i = 0; i < 16; i++) chk("rand_mem", mem[(32'h600 >> 2) + i], ref_mem[(32'h600 >> 2) + i]);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
